// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared async-read / sync-write data memory between the CPU and a DMA master.
// CPU wins by default; a starvation counter forces DMA in, then DMA may hold a bounded burst.
module mem_port_arbiter #(
    parameter int WIDTH      = 16,
    parameter int ADD_SIZE   = 10,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADD_SIZE-1:0] cpu_addr,
    input  logic [WIDTH-1:0]    cpu_wdata,
    output logic [WIDTH-1:0]    cpu_rdata,
    output logic                cpu_stall,

    input  logic                dma_req,
    input  logic                dma_we,
    input  logic [ADD_SIZE-1:0] dma_addr,
    input  logic [WIDTH-1:0]    dma_wdata,
    output logic                dma_gnt,
    output logic [WIDTH-1:0]    dma_rdata,

    output logic [ADD_SIZE-1:0] mem_addr,
    output logic                mem_we,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata,

    output logic [1:0]          owner
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(BURST_MAX + 1);

    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);
    localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);
    localparam logic [BW-1:0] BURST_ONE  = BW'(1);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    owner_t          r_owner;
    owner_t          w_grant;
    logic [SW-1:0]   r_starve_cnt;
    logic [SW-1:0]   w_starve_nxt;
    logic [BW-1:0]   r_burst_cnt;
    logic [BW-1:0]   w_burst_nxt;
    logic            w_burst_open;
    logic            w_starved;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= OWN_IDLE;
            r_starve_cnt <= '0;
            r_burst_cnt  <= '0;
        end else begin
            r_owner      <= w_grant;
            r_starve_cnt <= w_starve_nxt;
            r_burst_cnt  <= w_burst_nxt;
        end
    end

    assign w_burst_open = (r_owner == OWN_DMA) && (r_burst_cnt < BURST_LIM);
    assign w_starved    = (r_starve_cnt >= STARVE_LIM);

    // Reset is used as data here so nothing reaches memory while it is held.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_grant = OWN_IDLE;
        if (!rst) begin
            if (dma_req && (!cpu_req || w_burst_open || w_starved)) begin
                w_grant = OWN_DMA;
            end else if (cpu_req) begin
                w_grant = OWN_CPU;
            end
        end
    end

    always_comb begin
        w_burst_nxt  = '0;
        w_starve_nxt = '0;
        if (w_grant == OWN_DMA) begin
            if (r_owner != OWN_DMA) begin
                w_burst_nxt = BURST_ONE;
            end else if (r_burst_cnt >= BURST_LIM) begin
                w_burst_nxt = BURST_LIM;
            end else begin
                w_burst_nxt = r_burst_cnt + BURST_ONE;
            end
        end
        if ((w_grant == OWN_CPU) && dma_req) begin
            if (r_starve_cnt >= STARVE_LIM) begin
                w_starve_nxt = STARVE_LIM;
            end else begin
                w_starve_nxt = r_starve_cnt + STARVE_ONE;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        cpu_rdata = '0;
        dma_rdata = '0;
        unique case (w_grant)
            OWN_CPU: begin
                mem_addr  = cpu_addr;
                mem_we    = cpu_we;
                mem_wdata = cpu_wdata;
                cpu_rdata = mem_rdata;
            end
            OWN_DMA: begin
                mem_addr  = dma_addr;
                mem_we    = dma_we;
                mem_wdata = dma_wdata;
                dma_rdata = mem_rdata;
            end
            default: ;
        endcase
    end

    assign cpu_stall = cpu_req && (w_grant != OWN_CPU) && !rst;
    assign dma_gnt   = (w_grant == OWN_DMA);
    assign owner     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expectations are queued as stimulus is applied and
// compared against the DUT outputs mid-cycle, with a behavioural memory behind the port.
module tb_mem_port_arbiter;

    typedef enum logic [1:0] {G_NONE = 2'd0, G_CPU = 2'd1, G_DMA = 2'd2} gnt_e;

    typedef struct packed {
        logic        gnt;
        logic        stall;
        logic        we;
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic [15:0] crd;
        logic [15:0] drd;
    } outs_t;

    typedef struct packed {
        gnt_e  g;
        outs_t o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [9:0]  cpu_addr, dma_addr, mem_addr;
    logic [15:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic        cpu_stall, dma_gnt, mem_we;
    logic [1:0]  owner;

    logic [15:0] mem [1024];
    exp_t        sb [$];
    int          n_asrt = 0;
    int          n_fail = 0;

    mem_port_arbiter #(.WIDTH(16), .ADD_SIZE(10), .STARVE_MAX(4), .BURST_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    function automatic outs_t observe();
        outs_t o;
        o = '{gnt: dma_gnt, stall: cpu_stall, we: mem_we, addr: mem_addr,
              wdata: mem_wdata, crd: cpu_rdata, drd: dma_rdata};
        return o;
    endfunction

    // Drive one cycle of stimulus and queue what the port must do given the intended grant.
    task automatic apply(input logic c_req, input logic c_we, input logic [9:0] c_addr,
                         input logic [15:0] c_wd, input logic d_req, input logic d_we,
                         input logic [9:0] d_addr, input logic [15:0] d_wd, input gnt_e g);
        exp_t e;
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
        dma_req = d_req; dma_we = d_we; dma_addr = d_addr; dma_wdata = d_wd;
        e = '0;
        e.g = g;
        e.o.stall = c_req && (g != G_CPU) && !rst;
        case (g)
            G_CPU: begin
                e.o.we = c_we; e.o.addr = c_addr; e.o.wdata = c_wd; e.o.crd = mem[c_addr];
            end
            G_DMA: begin
                e.o.gnt = 1'b1;
                e.o.we = d_we; e.o.addr = d_addr; e.o.wdata = d_wd; e.o.drd = mem[d_addr];
            end
            default: ;
        endcase
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        outs_t got;
        rst = 1'b1;
        apply(1, 1, 10'd7, 16'h1234, 1, 1, 10'd9, 16'h5678, G_NONE);
        #2;
        got = observe(); e = sb.pop_front();
        n_asrt++;
        if (got !== e.o) begin
            n_fail++; $display("FAIL reset_outputs: got %h want %h", got, e.o);
        end
        repeat (2) @(posedge clk);
        #1;
        n_asrt++;
        if (owner !== 2'd0) begin
            n_fail++; $display("FAIL reset_owner: got %0d want 0", owner);
        end
        @(negedge clk);
        rst = 1'b0;
        apply(1, 0, 10'd7, 16'h0, 1, 0, 10'd9, 16'h0, G_CPU);
        #2;
        got = observe(); e = sb.pop_front();
        n_asrt++;
        if (got !== e.o) begin
            n_fail++; $display("FAIL reset_release_grant: got %h want %h", got, e.o);
        end
        @(posedge clk); #1;
        n_asrt++;
        if (owner !== 2'd1) begin
            n_fail++; $display("FAIL reset_release_owner: got %0d want 1", owner);
        end
    endtask

    task automatic test_cpu_only();
        exp_t e;
        outs_t got;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 0) apply(1, 1, 10'd5, 16'hBEEF, 0, 0, 10'd0, 16'h0, G_CPU);
            else        apply(1, 0, 10'd5, 16'h0000, 0, 0, 10'd0, 16'h0, G_CPU);
            #2;
            got = observe(); e = sb.pop_front();
            n_asrt++;
            if (got !== e.o) begin
                n_fail++; $display("FAIL cpu_only[%0d]: got %h want %h", i, got, e.o);
            end
        end
        n_asrt++;
        if (cpu_rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL cpu_readback: got %h want beef", cpu_rdata);
        end
        @(posedge clk);
    endtask

    task automatic test_dma_only();
        exp_t e;
        outs_t got;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (i < 20)
                apply(0, 0, 10'd0, 16'h0, 1, (i % 2) == 0, 10'(100 + i - (i % 2)),
                      16'(16'hA000 + i), G_DMA);
            else
                apply(1, 0, 10'd100, 16'h0, 1, 0, 10'd101, 16'h0, G_CPU);
            #2;
            got = observe(); e = sb.pop_front();
            n_asrt++;
            if (got !== e.o) begin
                n_fail++; $display("FAIL dma_only[%0d]: got %h want %h", i, got, e.o);
            end
            @(posedge clk); #1;
            n_asrt++;
            if (owner !== e.g) begin
                n_fail++; $display("FAIL dma_only_owner[%0d]: got %0d want %0d", i, owner, e.g);
            end
        end
    endtask

    task automatic test_contention();
        exp_t e;
        outs_t got;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 0)
                apply(0, 0, 10'd0, 16'h0, 0, 0, 10'd0, 16'h0, G_NONE);
            else
                apply(1, 1, 10'(300 + i), 16'(16'hC000 + i), 1, (i % 3) == 0,
                      10'(400 + i), 16'(16'hD000 + i), ((i - 1) % 12) < 4 ? G_CPU : G_DMA);
            #2;
            got = observe(); e = sb.pop_front();
            n_asrt++;
            if (got !== e.o) begin
                n_fail++; $display("FAIL contention[%0d]: got %h want %h", i, got, e.o);
            end
            @(posedge clk); #1;
            n_asrt++;
            if (owner !== e.g) begin
                n_fail++; $display("FAIL contention_owner[%0d]: got %0d want %0d", i, owner, e.g);
            end
        end
    endtask

    task automatic test_burst_cut();
        exp_t e;
        outs_t got;
        gnt_e g;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 0) g = G_NONE;
            else if (i <= 8) g = G_DMA;
            else if (i <= 12) g = G_CPU;
            else g = G_DMA;
            apply(i >= 3, 0, 10'(600 + i), 16'h0, i != 0, 0, 10'(700 + i), 16'h0, g);
            #2;
            got = observe(); e = sb.pop_front();
            n_asrt++;
            if (got !== e.o) begin
                n_fail++; $display("FAIL burst_cut[%0d]: got %h want %h", i, got, e.o);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        outs_t got;
        logic [15:0] old;
        old = mem[500];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) apply(0, 0, 10'd0, 16'h0, 0, 0, 10'd0, 16'h0, G_NONE);
            else        apply(0, i == 4, 10'd0, 16'h0, 1, i == 4, 10'd500, 16'hDEAD, G_DMA);
            #2;
            got = observe(); e = sb.pop_front();
            n_asrt++;
            if (got !== e.o) begin
                n_fail++; $display("FAIL mid_burst_pre[%0d]: got %h want %h", i, got, e.o);
            end
            if (i < 4) @(posedge clk);
        end
        rst = 1'b1;
        apply(0, 1, 10'd0, 16'h0, 1, 1, 10'd500, 16'hDEAD, G_NONE);
        #1;
        got = observe(); e = sb.pop_front();
        n_asrt++;
        if (got !== e.o) begin
            n_fail++; $display("FAIL mid_burst_reset_outputs: got %h want %h", got, e.o);
        end
        n_asrt++;
        if (owner !== 2'd0) begin
            n_fail++; $display("FAIL mid_burst_reset_owner: got %0d want 0", owner);
        end
        @(posedge clk); #1;
        n_asrt++;
        if (mem[500] !== old) begin
            n_fail++; $display("FAIL mid_burst_no_write: got %h want %h", mem[500], old);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst = 1'b0;
            apply(1, 0, 10'(800 + i), 16'h0, 1, 0, 10'(900 + i), 16'h0, i < 4 ? G_CPU : G_DMA);
            #2;
            got = observe(); e = sb.pop_front();
            n_asrt++;
            if (got !== e.o) begin
                n_fail++; $display("FAIL mid_burst_post[%0d]: got %h want %h", i, got, e.o);
            end
            @(posedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i) ^ 16'h5A5A;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        test_reset();
        test_cpu_only();
        test_dma_only();
        test_contention();
        test_burst_cut();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
